// File: rtl/sram_port_arb.sv
// -----------------------------------------------------------------------------
// sram_port_arb
//
// Shares one synchronous single-port SRAM between the instruction-fetch port
// (IF) and the data port (EX) of the 5-stage core. When both ports request in
// the same cycle, the data request is served first. The fetch address is
// captured and replayed one cycle later, and arb_stallreq is raised for the
// conflict cycle so that CTRL freezes the pipeline.
//
// Parameters:
//   AW - address width
//   DW - data width (byte-enable width is DW/8)
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   inst_sram_*            - core fetch bus (wen/wdata are ignored)
//   data_sram_*            - core data bus (wen==0 means load)
//   mem_*                  - physical SRAM bus (rdata valid 1 cycle after a read)
//   arb_stallreq           - stall request to CTRL, high in the conflict cycle
//   conflict_cnt           - number of conflict cycles seen
//
// Build option:
//   SRAM_ARB_CONFLICT_CNT_EN - when defined, conflict_cnt counts IDLE-state
//                              conflicts and wraps at 2^32. When undefined,
//                              conflict_cnt is tied to 0 and has no register.
// -----------------------------------------------------------------------------
module sram_port_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            inst_sram_en,
  input  logic [DW/8-1:0] inst_sram_wen,
  input  logic [AW-1:0]   inst_sram_addr,
  input  logic [DW-1:0]   inst_sram_wdata,
  output logic [DW-1:0]   inst_sram_rdata,

  input  logic            data_sram_en,
  input  logic [DW/8-1:0] data_sram_wen,
  input  logic [AW-1:0]   data_sram_addr,
  input  logic [DW-1:0]   data_sram_wdata,
  output logic [DW-1:0]   data_sram_rdata,

  output logic            mem_en,
  output logic [DW/8-1:0] mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,

  output logic            arb_stallreq,
  output logic [31:0]     conflict_cnt
);

  typedef enum logic {
    IDLE,
    REPLAY
  } state_t;

  // Identifies which requester owns the read data that the SRAM returns in
  // the following cycle.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_INST,
    TAG_DATA
  } tag_t;

  state_t        r_state;
  state_t        w_state_nxt;
  tag_t          r_tag;
  tag_t          w_tag_nxt;
  logic [AW-1:0] r_replay_addr;
  logic          w_capture;
  logic          w_conflict;
  logic [DW-1:0] r_inst_hold;
  logic [DW-1:0] r_data_hold;

  // The fetch port never writes; its write-side inputs are intentionally
  // ignored.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{inst_sram_wen, inst_sram_wdata};

  // ---------------------------------------------------------------------------
  // Next-state, SRAM issue and stall decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    w_state_nxt  = r_state;
    w_tag_nxt    = TAG_NONE;
    w_capture    = 1'b0;
    w_conflict   = 1'b0;
    mem_en       = 1'b0;
    mem_wen      = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    arb_stallreq = 1'b0;

    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (data_sram_en) begin
            // Data always wins; a simultaneous fetch is parked for replay.
            mem_en    = 1'b1;
            mem_wen   = data_sram_wen;
            mem_addr  = data_sram_addr;
            mem_wdata = data_sram_wdata;
            w_tag_nxt = (data_sram_wen == '0) ? TAG_DATA : TAG_NONE;
            if (inst_sram_en) begin
              w_capture    = 1'b1;
              w_conflict   = 1'b1;
              arb_stallreq = 1'b1;
              w_state_nxt  = REPLAY;
            end
          end else if (inst_sram_en) begin
            mem_en    = 1'b1;
            mem_addr  = inst_sram_addr;
            w_tag_nxt = TAG_INST;
          end
        end

        REPLAY: begin
          // The frozen EX stage still presents the request it already had
          // served, so the data port is ignored here; re-issuing it would
          // write a store twice.
          mem_en      = 1'b1;
          mem_addr    = r_replay_addr;
          w_tag_nxt   = TAG_INST;
          w_state_nxt = IDLE;
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, return tag and replay address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state       <= IDLE;
      r_tag         <= TAG_NONE;
      r_replay_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      if (w_capture) begin
        r_replay_addr <= inst_sram_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data return: bypass in the return cycle, hold value otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the hold registers are two plain registers, not a memory array,
    // so they take a reset value and read as 0 after reset.
    if (rst) begin
      r_inst_hold <= '0;
      r_data_hold <= '0;
    end else begin
      if (r_tag == TAG_INST) begin
        r_inst_hold <= mem_rdata;
      end
      if (r_tag == TAG_DATA) begin
        r_data_hold <= mem_rdata;
      end
    end
  end

  assign inst_sram_rdata = (r_tag == TAG_INST) ? mem_rdata : r_inst_hold;
  assign data_sram_rdata = (r_tag == TAG_DATA) ? mem_rdata : r_data_hold;

  // ---------------------------------------------------------------------------
  // Conflict counter
  // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_CONFLICT_CNT_EN
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict) begin
      // Wraps from 0xFFFFFFFF to 0 by plain 32-bit overflow.
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  logic w_unused_conflict;
  assign w_unused_conflict = w_conflict;
  assign conflict_cnt      = '0;
`endif

endmodule

// File: tb/tb_sram_port_arb.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arb
//
// Directed bench for sram_port_arb. Expected read data is pushed to a
// per-port queue when the request is issued and popped when the return cycle
// arrives. Inputs change 1 time unit after the rising edge; outputs are
// checked 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_sram_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            inst_sram_en;
  logic [DW/8-1:0] inst_sram_wen;
  logic [AW-1:0]   inst_sram_addr;
  logic [DW-1:0]   inst_sram_wdata;
  logic [DW-1:0]   inst_sram_rdata;
  logic            data_sram_en;
  logic [DW/8-1:0] data_sram_wen;
  logic [AW-1:0]   data_sram_addr;
  logic [DW-1:0]   data_sram_wdata;
  logic [DW-1:0]   data_sram_rdata;
  logic            mem_en;
  logic [DW/8-1:0] mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            arb_stallreq;
  logic [31:0]     conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int write_cnt = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_inst_hold = '0;
  logic [31:0] exp_data_hold = '0;
  logic [31:0] exp_cnt;

  sram_port_arb #(.AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .mem_en          (mem_en),
    .mem_wen         (mem_wen),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .arb_stallreq    (arb_stallreq),
    .conflict_cnt    (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts SRAM writes, sampled mid-cycle while the issue is stable.
  always @(negedge clk) begin
    if (mem_en && (mem_wen != '0)) write_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_inst_ret(input string tag);
    logic [31:0] exp;
    if (exp_inst_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed=%h expected=queued-fetch-data", tag, inst_sram_rdata);
    end else begin
      exp = exp_inst_q.pop_front();
      exp_inst_hold = exp;
      check(tag, inst_sram_rdata, exp);
    end
  endtask

  task automatic check_data_ret(input string tag);
    logic [31:0] exp;
    if (exp_data_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed=%h expected=queued-load-data", tag, data_sram_rdata);
    end else begin
      exp = exp_data_q.pop_front();
      exp_data_hold = exp;
      check(tag, data_sram_rdata, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram_en    = 1'b0;
    inst_sram_wen   = '0;
    inst_sram_addr  = '0;
    inst_sram_wdata = '0;
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
  endtask

  initial begin
    rst       = 1'b1;
    mem_rdata = '0;
    idle_inputs();

    // ---------------- Reset: SRAM bus forced quiet ----------------
    next_cycle();
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0000;
    settle();
    check("rst_mem_en",   {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    next_cycle();
    rst = 1'b0;
    idle_inputs();
    settle();
    check("rst_inst_rdata", inst_sram_rdata, 32'd0);
    check("rst_data_rdata", data_sram_rdata, 32'd0);
    check("rst_stall",      {31'd0, arb_stallreq}, 32'd0);
    check("rst_cnt",        conflict_cnt, 32'd0);

    // ---------------- 1. Fetch only ----------------
    next_cycle();
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0000;
    exp_inst_q.push_back(32'h2408_0001);
    settle();
    check("f_mem_en",   {31'd0, mem_en}, 32'd1);
    check("f_mem_addr", mem_addr, 32'hBFC0_0000);
    check("f_mem_wen",  {28'd0, mem_wen}, 32'd0);
    check("f_stall",    {31'd0, arb_stallreq}, 32'd0);

    next_cycle();
    idle_inputs();
    mem_rdata = 32'h2408_0001;
    settle();
    check_inst_ret("f_inst_ret");
    check("f_data_unchanged", data_sram_rdata, exp_data_hold);

    next_cycle();
    mem_rdata = 32'hFFFF_0000;
    settle();
    check("f_inst_held", inst_sram_rdata, exp_inst_hold);

    // ---------------- 2. Load/fetch conflict ----------------
    next_cycle();
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0010;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'h0;
    data_sram_addr = 32'h8000_1000;
    exp_data_q.push_back(32'hA5A5_0001);
    exp_inst_q.push_back(32'h5A5A_0002);
    settle();
    check("c_T_mem_addr", mem_addr, 32'h8000_1000);
    check("c_T_mem_wen",  {28'd0, mem_wen}, 32'd0);
    check("c_T_stall",    {31'd0, arb_stallreq}, 32'd1);

    next_cycle();
    mem_rdata = 32'hA5A5_0001;
    settle();
    check("c_T1_mem_en",   {31'd0, mem_en}, 32'd1);
    check("c_T1_mem_addr", mem_addr, 32'hBFC0_0010);
    check("c_T1_mem_wen",  {28'd0, mem_wen}, 32'd0);
    check("c_T1_stall",    {31'd0, arb_stallreq}, 32'd0);
    check_data_ret("c_T1_data_ret");
    check("c_T1_inst_unchanged", inst_sram_rdata, exp_inst_hold);

    next_cycle();
    idle_inputs();
    mem_rdata = 32'h5A5A_0002;
    settle();
    check_inst_ret("c_T2_inst_ret");
    check("c_T2_data_held", data_sram_rdata, exp_data_hold);

    // ---------------- 3. Store conflict ----------------
    next_cycle();
    write_cnt       = 0;
    inst_sram_en    = 1'b1;
    inst_sram_addr  = 32'hBFC0_0020;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = 32'h8000_2000;
    data_sram_wdata = 32'h1234_5678;
    mem_rdata       = 32'h0BAD_0BAD;
    exp_inst_q.push_back(32'h1111_0003);
    settle();
    check("s_T_mem_wen",   {28'd0, mem_wen}, 32'h0000_000F);
    check("s_T_mem_wdata", mem_wdata, 32'h1234_5678);
    check("s_T_mem_addr",  mem_addr, 32'h8000_2000);
    check("s_T_stall",     {31'd0, arb_stallreq}, 32'd1);

    next_cycle();
    mem_rdata = 32'h0BAD_1BAD;
    settle();
    check("s_T1_mem_wen",  {28'd0, mem_wen}, 32'd0);
    check("s_T1_mem_addr", mem_addr, 32'hBFC0_0020);
    check("s_T1_data_unchanged", data_sram_rdata, exp_data_hold);

    next_cycle();
    idle_inputs();
    mem_rdata = 32'h1111_0003;
    settle();
    check_inst_ret("s_T2_inst_ret");
    check("s_T2_data_unchanged", data_sram_rdata, exp_data_hold);
    next_cycle();
    check("s_write_count", write_cnt, 32'd1);

    // ---------------- 4. Hold after load ----------------
    data_sram_en   = 1'b1;
    data_sram_addr = 32'h8000_3000;
    exp_data_q.push_back(32'hDEAD_BEEF);
    settle();
    check("h_mem_en",   {31'd0, mem_en}, 32'd1);
    check("h_stall",    {31'd0, arb_stallreq}, 32'd0);

    next_cycle();
    idle_inputs();
    mem_rdata = 32'hDEAD_BEEF;
    settle();
    check_data_ret("h_data_ret");

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_rdata = $urandom;
      settle();
      check($sformatf("h_data_held_%0d", i), data_sram_rdata, 32'hDEAD_BEEF);
      check($sformatf("h_mem_en_%0d", i), {31'd0, mem_en}, 32'd0);
    end

    // ---------------- 5. Reset in REPLAY ----------------
    next_cycle();
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0030;
    data_sram_en   = 1'b1;
    data_sram_addr = 32'h8000_4000;
    settle();
    check("r_T_stall", {31'd0, arb_stallreq}, 32'd1);

    next_cycle();
    rst       = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    settle();
    check("r_T1_mem_en", {31'd0, mem_en}, 32'd0);

    next_cycle();
    rst = 1'b0;
    idle_inputs();
    mem_rdata = 32'h0F0F_0F0F;
    exp_inst_hold = '0;
    exp_data_hold = '0;
    settle();
    check("r_T2_inst_rdata", inst_sram_rdata, 32'd0);
    check("r_T2_data_rdata", data_sram_rdata, 32'd0);
    check("r_T2_stall",      {31'd0, arb_stallreq}, 32'd0);
    check("r_T2_mem_en",     {31'd0, mem_en}, 32'd0);

    // ---------------- 6. Back-to-back conflicts and counter ----------------
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      inst_sram_en   = 1'b1;
      inst_sram_addr = 32'hBFC0_0100 + 32'(i * 4);
      data_sram_en   = 1'b1;
      data_sram_addr = 32'h8000_5000 + 32'(i * 4);
      settle();
      check($sformatf("b_T_stall_%0d", i), {31'd0, arb_stallreq}, 32'd1);
      check($sformatf("b_T_addr_%0d", i), mem_addr, 32'h8000_5000 + 32'(i * 4));
      next_cycle();
      settle();
      check($sformatf("b_T1_stall_%0d", i), {31'd0, arb_stallreq}, 32'd0);
      check($sformatf("b_T1_addr_%0d", i), mem_addr, 32'hBFC0_0100 + 32'(i * 4));
    end
    next_cycle();
    idle_inputs();
    settle();
`ifdef SRAM_ARB_CONFLICT_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    check("cnt_after_3", conflict_cnt, exp_cnt);

`ifdef SRAM_ARB_CONFLICT_CNT_EN
    @(negedge clk);
    dut.r_conflict_cnt = 32'hFFFF_FFFF;
`endif
    next_cycle();
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0200;
    data_sram_en   = 1'b1;
    data_sram_addr = 32'h8000_6000;
    settle();
    next_cycle();
    idle_inputs();
    settle();
    next_cycle();
    check("cnt_wrap", conflict_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
